// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl
//   Drives three LEDs with one of eight patterns chosen by `mode`. A shared
//   tick divider paces the animated patterns; the LED output is registered
//   and always reflects the pattern state committed at the same clock edge.
//
// Parameters
//   TICK_DIV : clk cycles per pattern tick (2..65535)
//   PWM_BITS : width of the breathe-mode PWM counter and duty register
//
// Ports
//   clk      : system clock, all state on the rising edge
//   rst      : asynchronous active-high reset
//   mode     : pattern select (0 off, 1 on, 2 blink, 3 run left, 4 run right,
//              5 toggle, 6 breathe, 7 binary count)
//   key_led  : debounced active-low keys, idle 3'b111 (used in toggle mode)
//   led      : registered LED drive, 1 = lit
//   tick     : registered one-cycle pulse per pattern tick
module led_pattern_ctrl #(
  parameter int TICK_DIV = 1000,
  parameter int PWM_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode,
  input  logic [2:0] key_led,
  output logic [2:0] led,
  output logic       tick
);

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_BLINK   = 3'd2,
    MODE_RUN_L   = 3'd3,
    MODE_RUN_R   = 3'd4,
    MODE_TOGGLE  = 3'd5,
    MODE_BREATHE = 3'd6,
    MODE_BINARY  = 3'd7
  } mode_e;

  localparam logic [15:0]         TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

  mode_e               mode_q_reg,   mode_q_next;
  logic [15:0]         tick_cnt_reg, tick_cnt_next;
  logic                tick_reg,     tick_next;
  logic [2:0]          led_reg,      led_next;
  logic                blink_reg,    blink_next;
  logic [2:0]          pos_reg,      pos_next;
  logic [2:0]          tog_reg,      tog_next;
  logic [2:0]          key_prev_reg, key_prev_next;
  logic [PWM_BITS-1:0] pwm_cnt_reg,  pwm_cnt_next;
  logic [PWM_BITS-1:0] duty_reg,     duty_next;
  logic                dir_up_reg,   dir_up_next;
  logic [2:0]          bcnt_reg,     bcnt_next;

  mode_e      mode_in;
  mode_e      mode_eff;
  logic       mode_change;
  logic       tick_due;
  logic [2:0] key_fall;

  assign mode_in = mode_e'(mode);

  // Per-key falling-edge detect (keys are active-low, so 1->0 is a press).
  for (genvar gi = 0; gi < 3; gi++) begin : g_key_fall
    assign key_fall[gi] = key_prev_reg[gi] & ~key_led[gi];
  end

  always_comb begin
    mode_change   = (mode_in != mode_q_reg);
    // A mode change restarts the divider, so it swallows a tick due that edge.
    tick_due      = (tick_cnt_reg == TICK_LAST) && !mode_change;
    // The pattern that owns this edge: the new one on a change, else the current.
    mode_eff      = mode_change ? mode_in : mode_q_reg;

    mode_q_next   = mode_in;
    tick_cnt_next = (mode_change || (tick_cnt_reg == TICK_LAST)) ? 16'd0
                                                                  : tick_cnt_reg + 16'd1;
    tick_next     = tick_due;
    blink_next    = blink_reg;
    pos_next      = pos_reg;
    tog_next      = tog_reg;
    // Sampled in every mode so re-entering toggle mode with a key already
    // held low is not mistaken for a fresh press.
    key_prev_next = key_led;
    pwm_cnt_next  = pwm_cnt_reg + 1'b1;
    duty_next     = duty_reg;
    dir_up_next   = dir_up_reg;
    bcnt_next     = bcnt_reg;
    led_next      = 3'b000;

    if (mode_eff == MODE_TOGGLE) begin
      tog_next = tog_reg ^ key_fall;
    end

    if (mode_change) begin
      case (mode_in)
        MODE_BLINK:   blink_next = 1'b0;
        MODE_RUN_L:   pos_next   = 3'b001;
        MODE_RUN_R:   pos_next   = 3'b100;
        MODE_BREATHE: begin
          duty_next   = '0;
          dir_up_next = 1'b1;
        end
        MODE_BINARY:  bcnt_next  = 3'b000;
        default: ;
      endcase
    end else if (tick_due) begin
      case (mode_q_reg)
        MODE_BLINK: blink_next = ~blink_reg;
        MODE_RUN_L: pos_next   = (pos_reg == 3'b100) ? 3'b001 : {pos_reg[1:0], 1'b0};
        MODE_RUN_R: pos_next   = (pos_reg == 3'b001) ? 3'b100 : {1'b0, pos_reg[2:1]};
        MODE_BREATHE: begin
          // Triangle sweep; each endpoint is held for exactly one tick.
          if (dir_up_reg) begin
            if (duty_reg == DUTY_MAX) begin
              duty_next   = duty_reg - 1'b1;
              dir_up_next = 1'b0;
            end else begin
              duty_next   = duty_reg + 1'b1;
            end
          end else begin
            if (duty_reg == '0) begin
              duty_next   = duty_reg + 1'b1;
              dir_up_next = 1'b1;
            end else begin
              duty_next   = duty_reg - 1'b1;
            end
          end
        end
        MODE_BINARY: bcnt_next = bcnt_reg + 3'd1;
        default: ;
      endcase
    end

    // LED is built from the next-state values so it changes on the same
    // edge as the state it shows.
    case (mode_eff)
      MODE_ON:      led_next = 3'b111;
      MODE_BLINK:   led_next = {3{blink_next}};
      MODE_RUN_L:   led_next = pos_next;
      MODE_RUN_R:   led_next = pos_next;
      MODE_TOGGLE:  led_next = tog_next;
      MODE_BREATHE: led_next = {3{pwm_cnt_next < duty_next}};
      MODE_BINARY:  led_next = bcnt_next;
      default:      led_next = 3'b000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q_reg   <= MODE_OFF;
      tick_cnt_reg <= 16'd0;
      tick_reg     <= 1'b0;
      led_reg      <= 3'b000;
      blink_reg    <= 1'b0;
      pos_reg      <= 3'b001;
      tog_reg      <= 3'b000;
      key_prev_reg <= 3'b111;
      pwm_cnt_reg  <= '0;
      duty_reg     <= '0;
      dir_up_reg   <= 1'b1;
      bcnt_reg     <= 3'b000;
    end else begin
      mode_q_reg   <= mode_q_next;
      tick_cnt_reg <= tick_cnt_next;
      tick_reg     <= tick_next;
      led_reg      <= led_next;
      blink_reg    <= blink_next;
      pos_reg      <= pos_next;
      tog_reg      <= tog_next;
      key_prev_reg <= key_prev_next;
      pwm_cnt_reg  <= pwm_cnt_next;
      duty_reg     <= duty_next;
      dir_up_reg   <= dir_up_next;
      bcnt_reg     <= bcnt_next;
    end
  end

  assign led  = led_reg;
  assign tick = tick_reg;

endmodule

// File: doc/led_pattern_ctrl.md
LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000, clk cycles per pattern tick (legal range 2..65535).
REQ-002 SHALL have parameter PWM_BITS, default 4, width of PWM counter and duty register.
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port mode  input  3  pattern select, from key_counter count output, synchronous to clk.
REQ-006 SHALL have port key_led  input  3  debounced LED keys, active-low, idle 3'b111, synchronous to clk.
REQ-007 SHALL have port led  output  3  LED drive, registered, 1 = lit.
REQ-008 SHALL have port tick  output  1  registered one-cycle pulse per pattern tick.

Function
REQ-009 SHALL keep mode_q (3 bits); a mode change is any edge where mode != mode_q; at that edge mode_q <= mode.
REQ-010 SHALL run tick_cnt 0..TICK_DIV-1; tick asserts for the cycle after tick_cnt == TICK_DIV-1, then tick_cnt wraps to 0.
REQ-011 SHALL, on a mode change, clear tick_cnt to 0, suppress any tick on that edge, and load new-mode entry state.
REQ-012 SHALL update led at the same edge as the state it reflects; a mode change shows the new entry pattern one edge after mode changes.
REQ-013 Mode 0: led = 3'b000.
REQ-014 Mode 1: led = 3'b111.
REQ-015 Mode 2 (blink): blink bit entry 0; toggles per tick; led = {3{blink}}.
REQ-016 Mode 3 (run left): pos entry 3'b001; per tick shift left; 3'b100 wraps to 3'b001; led = pos.
REQ-017 Mode 4 (run right): pos entry 3'b100; per tick shift right; 3'b001 wraps to 3'b100; led = pos.
REQ-018 Mode 5 (toggle): tog[2:0] per-key; falling edge (1->0) of key_led[i] toggles tog[i] at next edge; simultaneous edges toggle each affected bit; led = tog.
REQ-019 tog SHALL be preserved across mode changes, cleared only by rst; key edges in modes other than 5 SHALL be ignored.
REQ-020 SHALL register key_led into key_prev every cycle in all modes, so re-entering mode 5 with a key held low does not create a spurious edge.
REQ-021 Mode 6 (breathe): pwm_cnt free-runs every cycle, wraps; duty entry 0, direction up; per tick duty +1 up to 2^PWM_BITS-1, then -1 down to 0, then up (triangle, endpoints held one tick each).
REQ-022 Mode 6 output: led = {3{pwm_cnt < duty}}; duty 0 gives all-off, max duty gives on (2^PWM_BITS-1) of 2^PWM_BITS cycles.
REQ-023 Mode 7 (binary): bcnt entry 3'b000; per tick +1 mod 8; led = bcnt.
REQ-024 SHALL assert tick in every mode, including 0, 1 and 5.

Reset
REQ-025 While rst = 1: led = 3'b000, tick = 0, mode_q = 0, tick_cnt = 0, tog = 0, key_prev = 3'b111, blink = 0, pos = 3'b001, duty = 0 with direction up, pwm_cnt = 0, bcnt = 0.
REQ-026 Reset asserted mid-pattern SHALL clear immediately without waiting for clk; after release, the first mode change or tick proceeds per REQ-009..REQ-023.

Verification
REQ-027 TICK_DIV=4; rst released, mode=3 -> led 001 one edge later, then 010, 100, 001 at ticks every 4 cycles.
REQ-028 Mode 5, key_led 111->011->111 -> led 100; then 111->010 (bits 0,2 low) -> led 001; switch to mode 1 and back to 5 with key_led still 010 -> led 001, no toggle.
REQ-029 Mode 6, TICK_DIV=4, PWM_BITS=4 -> duty goes 0..15..0; with duty=8, led high exactly 8 of 16 cycles.
REQ-030 Mode 7 held 9 ticks -> led 000,001,...,111,000,001; tick pulses exactly 1 cycle wide.
REQ-031 Mode change 2->4 one cycle before a tick is due -> no tick that edge, led 100 next edge, tick_cnt restarts from 0.
REQ-032 rst asserted mid mode 4 between edges -> led 000 immediately; after release, led 000 until mode differs from 0.
